// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Includes the boot-loader FSM states and widths.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int BOOT_CNT_W = 16;

  typedef enum logic [2:0] {
    LD_LEN0,
    LD_LEN1,
    LD_DATA,
    LD_CHK,
    LD_DONE,
    LD_ERR
  } ld_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into XLEN-bit words.
// word_valid pulses for one cycle after every 4th byte.
module byte_word_packer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [7:0]      byte_data,
  input  logic            byte_stb,
  output logic [XLEN-1:0] word,
  output logic            word_valid
);

  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx        <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_stb && (idx == 2'd3);
      if (byte_stb) begin
        // Shift right so the first byte lands in [7:0].
        word <= {byte_data, word[XLEN-1:8]};
        idx  <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a checksummed image into instruction memory and
// holds the core in reset until the image is verified.
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  load_req,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [XLEN-1:0]       imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [BOOT_CNT_W-1:0] words_loaded
);

  localparam logic [BOOT_CNT_W:0] MAX_CNT =
    (BOOT_CNT_W+1)'(2**ADDR_W);

  ld_state_e state, state_nxt;

  logic [7:0]            cnt_lo;
  logic [BOOT_CNT_W-1:0] cnt;
  logic [BOOT_CNT_W-1:0] cnt_full;
  logic [BOOT_CNT_W+1:0] data_bytes;
  logic [7:0]            csum;
  logic                  xfer;
  logic                  last_byte;
  logic                  restart;
  logic                  pk_valid;
  logic [XLEN-1:0]       pk_word;

  assign xfer      = rx_valid && rx_ready;
  assign cnt_full  = {rx_data, cnt_lo};
  assign last_byte = data_bytes == ({cnt, 2'b00} - 1'b1);
  assign restart   = load_req &&
                     (state == LD_DONE || state == LD_ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= LD_LEN0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LD_LEN0: if (xfer) state_nxt = LD_LEN1;
      LD_LEN1: begin
        if (xfer) begin
          if ({1'b0, cnt_full} > MAX_CNT)
            state_nxt = LD_ERR;
          else if (cnt_full == '0)
            state_nxt = LD_CHK;
          else
            state_nxt = LD_DATA;
        end
      end
      LD_DATA: if (xfer && last_byte) state_nxt = LD_CHK;
      LD_CHK: begin
        if (xfer)
          state_nxt = (rx_data == csum) ? LD_DONE : LD_ERR;
      end
      LD_DONE: if (load_req) state_nxt = LD_LEN0;
      LD_ERR:  if (load_req) state_nxt = LD_LEN0;
      default: state_nxt = LD_LEN0;
    endcase
  end

  // Status outputs follow the next state so they line up
  // with the state register rather than lag it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready  <= 1'b0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rx_ready  <= !(state_nxt == LD_DONE ||
                     state_nxt == LD_ERR);
      core_rst  <= state_nxt != LD_DONE;
      load_done <= state_nxt == LD_DONE;
      load_err  <= state_nxt == LD_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo       <= '0;
      cnt          <= '0;
      data_bytes   <= '0;
      csum         <= '0;
      words_loaded <= '0;
    end else if (restart) begin
      data_bytes   <= '0;
      csum         <= '0;
      words_loaded <= '0;
    end else begin
      if (pk_valid)
        words_loaded <= words_loaded + 1'b1;
      if (xfer) begin
        unique case (state)
          LD_LEN0: cnt_lo <= rx_data;
          LD_LEN1: begin
            cnt        <= cnt_full;
            data_bytes <= '0;
          end
          LD_DATA: begin
            csum       <= csum ^ rx_data;
            data_bytes <= data_bytes + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_data  (rx_data),
    .byte_stb   (xfer && state == LD_DATA),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // The write happens the cycle before words_loaded
  // increments, so it still holds this word's index.
  assign imem_we    = pk_valid;
  assign imem_wdata = pk_word;
  assign imem_addr  = words_loaded[ADDR_W-1:0];

endmodule
